// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// per-size byte masks.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;  // illegal encoding

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC1 = 2'd1,
    ST_ACC2 = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  // Right-justified byte mask for an access size; illegal size touches nothing.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    size_mask = MASK_B;
      SZ_H:    size_mask = MASK_H;
      SZ_W:    size_mask = MASK_W;
      default: size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte-enable generation across two words, store
// data lane shifting for both memory cycles, and load extract/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [7:0]  o_m8,
  output logic        o_cross,
  output logic [31:0] o_wdata_lo,
  output logic [31:0] o_wdata_hi,
  output logic [31:0] o_rdata
);

  logic [4:0]  w_sh;
  logic [63:0] w_st;
  logic [31:0] w_ld;

  // Byte offset expressed as a bit shift amount.
  assign w_sh = {i_off, 3'b000};

  // Mask spread over two words; any bit in the upper word means a second cycle.
  assign o_m8    = {4'b0000, size_mask(i_size)} << i_off;
  assign o_cross = |o_m8[7:4];

  // Store data shifted into a 64-bit window: low half goes to ACC1, the
  // spill-over into the high half goes to ACC2.
  assign w_st       = {32'h0, i_wdata} << w_sh;
  assign o_wdata_lo = w_st[31:0];
  assign o_wdata_hi = w_st[63:32];

  // Load bytes brought down to bit 0 from the two-word window.
  assign w_ld = 32'({i_hi, i_lo} >> w_sh);

  // Truncate the loaded value to the access size and extend it.
  always_comb begin
    o_rdata = 32'h0;
    case (i_size)
      SZ_B:    o_rdata = {{24{~i_unsigned & w_ld[7]}}, w_ld[7:0]};
      SZ_H:    o_rdata = {{16{~i_unsigned & w_ld[15]}}, w_ld[15:0]};
      SZ_W:    o_rdata = w_ld;
      default: o_rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a byte-banked data memory.
// Handshake: a request is accepted on a clock edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, and req_* inputs
// are ignored at every other time. Completion is a single-cycle rsp_valid
// pulse with rsp_err and rsp_rdata valid alongside it.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] daddr,
  output logic [3:0]  dwe,
  output logic [31:0] dwdata,
  input  logic [31:0] drdata
);

  lsu_state_t  r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_lo;
  logic [31:0] r_daddr;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic [31:0] w_base;
  logic [31:0] w_next;
  logic [31:0] w_hi;
  logic [31:0] w_lo;
  logic [7:0]  w_m8;
  logic        w_cross;
  logic [31:0] w_wdata_lo;
  logic [31:0] w_wdata_hi;
  logic [31:0] w_rdata;

  // First word of the access and its successor; the +4 wraps at the top of memory.
  assign w_base = {r_addr[31:2], 2'b00};
  assign w_next = w_base + 32'd4;

  // In ACC1 the window is {0, drdata}; in ACC2 it is {drdata, first word}.
  assign w_hi = (r_state == ST_ACC2) ? drdata : 32'h0;
  assign w_lo = (r_state == ST_ACC2) ? r_lo : drdata;

  lsu_align u_align (
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_off      (r_addr[1:0]),
    .i_wdata    (r_wdata),
    .i_hi       (w_hi),
    .i_lo       (w_lo),
    .o_m8       (w_m8),
    .o_cross    (w_cross),
    .o_wdata_lo (w_wdata_lo),
    .o_wdata_hi (w_wdata_hi),
    .o_rdata    (w_rdata)
  );

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

  // Memory-side drive: decoded from state so reset drops dwe immediately;
  // daddr holds its last driven value outside the access cycles.
  always_comb begin
    daddr  = r_daddr;
    dwe    = 4'b0000;
    dwdata = 32'h0;
    case (r_state)
      ST_ACC1: begin
        daddr  = w_base;
        dwe    = r_we ? w_m8[3:0] : 4'b0000;
        dwdata = w_wdata_lo;
      end
      ST_ACC2: begin
        daddr  = w_next;
        dwe    = r_we ? w_m8[7:4] : 4'b0000;
        dwdata = w_wdata_hi;
      end
      default: ;
    endcase
  end

  // Request capture, access sequencing and registered response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_size      <= SZ_B;
      r_unsigned  <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_lo        <= 32'h0;
      r_daddr     <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            if (req_size == SZ_X) begin
              r_state     <= ST_DONE;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= 32'h0;
            end else begin
              r_state <= ST_ACC1;
            end
          end
        end
        ST_ACC1: begin
          r_lo    <= drdata;
          r_daddr <= w_base;
          if (w_cross) begin
            r_state <= ST_ACC2;
          end else begin
            r_state     <= ST_DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= r_we ? 32'h0 : w_rdata;
          end
        end
        ST_ACC2: begin
          r_daddr     <= w_next;
          r_state     <= ST_DONE;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= r_we ? 32'h0 : w_rdata;
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= 32'h0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the CPU execute stage and the byte-banked data memory. Converts a CPU load/store request (address, size, signedness, store data) into the memory's word address, 4-bit byte write enables and lane-aligned write data, and converts the raw 32-bit read word back into an extended load result. Accesses that cross a word boundary are split into two back-to-back memory cycles, sequenced by a small FSM with a valid/ready request handshake and a one-cycle response pulse.

## Interface
Parameters:
- none; memory geometry and encodings come from `lsu_pkg`

Ports:
- Clock and reset (already decided): `clk`, the single clock; `reset`, asynchronous, active-high.
- `clk`  in  1  clock; all state changes on posedge
- `reset`  in  1  asynchronous, active-high
- `req_valid`  in  1  CPU request present
- `req_ready`  out  1  LSU can accept; high only in IDLE
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-justified
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_err`  out  1  qualifies rsp_valid; illegal size
- `rsp_rdata`  out  32  extended load result; 0 for stores and errors
- `daddr`  out  32  memory byte address, always word-aligned (bits [1:0]=0)
- `dwe`  out  4  byte write enables, bit n = byte lane n
- `dwdata`  out  32  lane-aligned write data
- `drdata`  in  32  memory read word, combinational from daddr

## Operation
- States: IDLE, ACC1, ACC2, DONE.
- IDLE: req_ready=1. On req_valid, capture we/size/unsigned/addr/wdata. Go to DONE with err=1 for size 11, otherwise ACC1.
- off = addr[1:0]; mask = 0001/0011/1111 by size; m8 = {4'b0,mask} << off (8 bits); cross = |m8[7:4].
- ACC1: daddr = {addr[31:2],2'b00}; dwe = we ? m8[3:0] : 0; dwdata = wdata << 8*off. Latch drdata into lo at the clock edge. Next: ACC2 if cross, else DONE.
- ACC2: daddr = ACC1 address + 4, wrapping 0xFFFFFFFC to 0x00000000; dwe = we ? m8[7:4] : 0; dwdata = wdata >> 8*(4-off). Latch drdata into hi. Next: DONE.
- Load result: ({hi,lo} >> 8*off), truncated to size, then sign- or zero-extended. hi is treated as 0 when not crossing.
- DONE: rsp_valid=1 for exactly one cycle, with rsp_err and rsp_rdata registered. Next: IDLE.
- Outside ACC1/ACC2: dwe=0, dwdata=0, daddr holds the last driven value.
- Reset value of every output: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, daddr=0, dwe=0, dwdata=0. State returns to IDLE.

## Timing
- Accept edge = cycle 0.
- Aligned access: ACC1 in cycle 1, rsp_valid in cycle 2.
- Crossing access: ACC1 in cycle 1, ACC2 in cycle 2, rsp_valid in cycle 3.
- Illegal size: rsp_valid with rsp_err=1 in cycle 1. No memory cycle, dwe stays 0.
- Stores commit at the ACC1/ACC2 clock edge, because the memory writes on posedge.
- Next accept is possible in the cycle after DONE (IDLE). Back-to-back throughput is 1 request per 3 cycles when aligned.
- reset mid-operation forces dwe=0 immediately. A crossing store interrupted after ACC1 leaves its first half written, and no response is produced.
- req_* inputs are ignored outside IDLE; the CPU must hold them only until accepted.

## Structure
- `lsu_pkg`: size encodings (SZ_B, SZ_H, SZ_W), the state enum, and byte-mask constants.
- Sub-module `lsu_align`: purely combinational. Covers m8/cross generation, store lane shift for both halves, and load extract/extend from {hi,lo}. The FSM and capture registers stay in `load_store_unit`.

## Test plan
- Word store 0xDEADBEEF at 0x100, then word load 0x100 -> ACC1 dwe=1111, daddr=0x100; load rsp_rdata=0xDEADBEEF at cycle 2.
- Byte store 0x000000A5 at 0x203, then signed byte load 0x203 -> dwe=1000, dwdata=0xA5000000; rsp_rdata=0xFFFFFFA5. Unsigned load -> 0x000000A5.
- Half store 0x1234 at 0x303 (crossing) -> ACC1 daddr=0x300, dwe=1000, dwdata[31:24]=0x34; ACC2 daddr=0x304, dwe=0001, dwdata[7:0]=0x12; half load 0x303 -> 0x00001234 at cycle 3.
- Word load at 0xFFFFFFFE -> ACC1 daddr=0xFFFFFFFC, ACC2 daddr=0x00000000; result = {mem[1:0] of word 0, mem[3:2] of word 0xFFFFFFFC}.
- req_size=11 store -> rsp_valid and rsp_err=1 at cycle 1, dwe=0 throughout, rsp_rdata=0.
- reset asserted during ACC2 of a crossing store -> dwe=0 at once, no rsp_valid, req_ready=1; the first-half bytes read back as written.
